sorted_stream_out: RTL and testbench

Downstream companion to the radix sorter: detects the sorter's rising `done`, snapshots its N-element sorted array, and streams the elements out one per handshake, smallest first (index 0 first), over a valid/ready interface. It decouples the sorter's parallel output array from a narrow serial consumer such as a UART or FIFO. It also flags frames lost because the sorter finished again while a previous frame was still streaming.

---
 rtl/sorted_stream_out.sv | 185 ++++++++++++++++++
 tb/tb_sorted_stream_out.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sorted_stream_out.sv
// Snapshots the radix sorter's array on a rising sort_done and streams it out
// smallest-first over valid/ready. Optional ordering check: SORT_STREAM_CHECK_EN.
module sorted_stream_out #(
    parameter int N     = 8,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sort_done,
    input  logic [N-1:0][WIDTH-1:0]     sort_data,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(N)-1:0]        out_index,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun,
    output logic                        order_err
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_done_q;
    logic [WIDTH-1:0] r_buf [N];
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic [IW-1:0]    w_idx_inc;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_out_valid;
    logic             r_out_last;
    logic             w_last_nxt;
    logic             r_frame_done;
    logic             r_overrun;
    logic             w_overrun_nxt;
    logic             w_rise;
    logic             w_xfer;
    logic             w_at_last;
    logic             w_capture;

    assign w_rise    = sort_done & ~r_done_q;
    assign w_xfer    = (r_state == S_STREAM) & out_ready;
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_capture = (r_state == S_IDLE) & w_rise;
    assign w_idx_inc = r_idx + IW'(1);

    // Edge detector history for sort_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= sort_done;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_state_nxt = S_STREAM;
                else        w_state_nxt = S_IDLE;
            end
            S_STREAM: begin
                if (w_xfer && w_at_last) w_state_nxt = S_IDLE;
                else                     w_state_nxt = S_STREAM;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; a rise while streaming is dropped.
    always_comb begin
        w_idx_nxt     = r_idx;
        w_data_nxt    = r_out_data;
        w_overrun_nxt = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_idx_nxt  = {IW{1'b0}};
                    w_data_nxt = sort_data[0];
                end else begin
                    w_idx_nxt  = r_idx;
                    w_data_nxt = r_out_data;
                end
            end
            S_STREAM: begin
                w_overrun_nxt = r_overrun | w_rise;
                if (w_xfer && !w_at_last) begin
                    w_idx_nxt  = w_idx_inc;
                    w_data_nxt = r_buf[w_idx_inc];
                end else begin
                    w_idx_nxt  = r_idx;
                    w_data_nxt = r_out_data;
                end
            end
            default: begin
                w_idx_nxt     = r_idx;
                w_data_nxt    = r_out_data;
                w_overrun_nxt = r_overrun;
            end
        endcase
        w_last_nxt = (w_state_nxt == S_STREAM) && (w_idx_nxt == LAST_IDX);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= {IW{1'b0}};
            r_out_data   <= {WIDTH{1'b0}};
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_idx        <= w_idx_nxt;
            r_out_data   <= w_data_nxt;
            r_out_valid  <= (w_state_nxt == S_STREAM);
            r_out_last   <= w_last_nxt;
            r_frame_done <= w_xfer & w_at_last;
            r_overrun    <= w_overrun_nxt;
        end
    end

    // Frame snapshot taken only when a rise is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_buf[i] <= {WIDTH{1'b0}};
        end else if (w_capture) begin
            for (int i = 0; i < N; i++) r_buf[i] <= sort_data[i];
        end else begin
            for (int i = 0; i < N; i++) r_buf[i] <= r_buf[i];
        end
    end

`ifdef SORT_STREAM_CHECK_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_order_err;

    // r_out_data is buf[idx] whenever a transfer happens, so compare against it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= {WIDTH{1'b0}};
            r_order_err <= 1'b0;
        end else if (w_xfer) begin
            r_prev <= r_out_data;
            if ((r_idx != {IW{1'b0}}) && (r_out_data < r_prev)) r_order_err <= 1'b1;
        end else begin
            r_prev      <= r_prev;
            r_order_err <= r_order_err;
        end
    end

    assign order_err = r_order_err;
`else
    assign order_err = 1'b0;
`endif

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_index  = r_idx;
    assign busy       = r_out_valid;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sorted_stream_out.sv
// Directed and random checks of sorted_stream_out against a queue-based frame model.
module tb_sorted_stream_out;

    localparam int N     = 8;
    localparam int WIDTH = 8;

    logic                    clk;
    logic                    rst;
    logic                    sort_done;
    logic [N-1:0][WIDTH-1:0] sort_data;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic [$clog2(N)-1:0]    out_index;
    logic                    busy;
    logic                    frame_done;
    logic                    overrun;
    logic                    order_err;

    sorted_stream_out #(.N(N), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sort_done  (sort_done),
        .sort_data  (sort_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_index  (out_index),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .order_err  (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the frame still to be delivered, head = current element.
    logic [WIDTH-1:0] m_q[$];
    logic             m_done_prev = 1'b0;
    logic             m_ovr = 1'b0;
    logic             m_fd = 1'b0;
    logic             m_oerr = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic             m_after_rst = 1'b1;
`ifdef SORT_STREAM_CHECK_EN
    logic [WIDTH-1:0] m_prev = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task model_edge();
        bit rise;
        bit streaming;
        bit xfer;
        if (rst) begin
            m_q.delete();
            m_done_prev = 1'b0;
            m_ovr       = 1'b0;
            m_fd        = 1'b0;
            m_oerr      = 1'b0;
            m_data      = '0;
            m_after_rst = 1'b1;
`ifdef SORT_STREAM_CHECK_EN
            m_prev      = '0;
`endif
        end else begin
            rise        = sort_done && !m_done_prev;
            m_done_prev = sort_done;
            streaming   = (m_q.size() != 0);
            xfer        = streaming && out_ready;
            m_fd        = xfer && (m_q.size() == 1);
            if (rise && streaming) m_ovr = 1'b1;
            if (xfer) begin
`ifdef SORT_STREAM_CHECK_EN
                if ((N - m_q.size()) > 0 && m_q[0] < m_prev) m_oerr = 1'b1;
                m_prev = m_q[0];
`endif
                void'(m_q.pop_front());
            end
            if (rise && !streaming) begin
                for (int i = 0; i < N; i++) m_q.push_back(sort_data[i]);
                m_after_rst = 1'b0;
            end
            if (m_q.size() != 0) m_data = m_q[0];
        end
    endtask

    task check_outputs();
        chk("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
        chk("busy",       32'(busy),       32'(m_q.size() != 0));
        chk("out_data",   32'(out_data),   32'(m_data));
        chk("out_last",   32'(out_last),   32'(m_q.size() == 1));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("order_err",  32'(order_err),  32'(m_oerr));
        if (m_q.size() != 0)  chk("out_index", 32'(out_index), 32'(N - m_q.size()));
        else if (m_after_rst) chk("out_index_rst", 32'(out_index), 32'd0);
    endtask

    task run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task new_frame(input bit sorted);
        int v;
        v = 0;
        for (int i = 0; i < N; i++) begin
            if (sorted) begin
                v = v + int'($urandom_range(0, 36));
                if (v > 255) v = 255;
            end else begin
                v = int'($urandom_range(0, 255));
            end
            sort_data[i] = v[WIDTH-1:0];
        end
    endtask

    initial begin
        rst = 1'b1; sort_done = 1'b0; out_ready = 1'b0; sort_data = '0;
        run(2);
        rst = 1'b0;
        run(1);

        // Basic frame, elements 0..7 = 3,7,12,40,41,99,200,255
        sort_data = {8'd255, 8'd200, 8'd99, 8'd41, 8'd40, 8'd12, 8'd7, 8'd3};
        out_ready = 1'b1; sort_done = 1'b1;
        run(12);

        // Level hold: done stays high, no new frame
        for (int k = 0; k < 50; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            run(1);
        end

        // Backpressure with ready pattern 1,0,0,1
        sort_done = 1'b0; run(1);
        new_frame(1'b1); sort_done = 1'b1;
        for (int k = 0; k < 40; k++) begin
            out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            run(1);
        end

        // Overrun: done falls and rises while idx = 3
        sort_done = 1'b0; out_ready = 1'b1; run(1);
        new_frame(1'b1); sort_done = 1'b1;
        run(1);
        run(3);
        out_ready = 1'b0; sort_done = 1'b0; run(1);
        sort_done = 1'b1; new_frame(1'b1); run(1);
        out_ready = 1'b1; run(12);

        // Reset mid-frame at idx = 5, done held high through release
        sort_done = 1'b0; run(1);
        new_frame(1'b1); sort_done = 1'b1;
        run(1);
        run(5);
        rst = 1'b1; run(1);
        rst = 1'b0; new_frame(1'b1); run(12);

        // Rise coinciding with the final transfer counts as overrun
        sort_done = 1'b0; run(1);
        new_frame(1'b1); sort_done = 1'b1;
        run(1);
        run(7);
        out_ready = 1'b0; sort_done = 1'b0; run(2);
        out_ready = 1'b1; sort_done = 1'b1; run(1);
        run(6);

        // Out-of-order frame, elements 0..7 = 1,2,5,4,6,7,8,9
        sort_done = 1'b0; run(1);
        sort_data = {8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd5, 8'd2, 8'd1};
        sort_done = 1'b1; run(12);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                sort_done = ~sort_done;
                if (!sort_done) new_frame($urandom_range(0, 3) != 0);
            end
            run(1);
        end
        rst = 1'b0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
